// File: rtl/ysyx_23060332_mem_arbiter_if.sv
// Bus bundle for the memory arbiter: IFU and LSU front-end handshakes plus the shared memory port.
// The arbiter uses the slave view; the master view is the surrounding environment.
interface ysyx_23060332_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_23060332_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between IFU and LSU,
// with a single registered transaction outstanding at a time.
module ysyx_23060332_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_23060332_mem_arbiter_if.slave bus,
    output logic busy,
    output logic owner
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
    logic              ifu_resp_q, ifu_resp_d;
    logic              lsu_resp_q, lsu_resp_d;
    logic              grant_lsu, grant_ifu;

    // On a tie the requester that did not own the last grant wins.
    assign grant_lsu = bus.lsu_req_valid & (~bus.ifu_req_valid | ~owner_q);
    assign grant_ifu = bus.ifu_req_valid & ~grant_lsu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
            ifu_resp_q  <= 1'b0;
            lsu_resp_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
            ifu_resp_q  <= ifu_resp_d;
            lsu_resp_q  <= lsu_resp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        ifu_resp_d  = 1'b0;
        lsu_resp_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_lsu) begin
                    owner_d = 1'b1;
                    addr_d  = bus.lsu_addr;
                    wen_d   = bus.lsu_wen;
                    wdata_d = bus.lsu_wdata;
                    wmask_d = bus.lsu_wmask;
                    state_d = REQ;
                end else if (grant_ifu) begin
                    owner_d = 1'b0;
                    addr_d  = bus.ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    if (owner_q) begin
                        lsu_rdata_d = bus.mem_rdata;
                        lsu_resp_d  = 1'b1;
                    end else begin
                        ifu_rdata_d = bus.mem_rdata;
                        ifu_resp_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is gated by reset so nothing looks accepted while reset is held.
    assign bus.ifu_req_ready  = rst_n & (state_q == IDLE) & grant_ifu;
    assign bus.lsu_req_ready  = rst_n & (state_q == IDLE) & grant_lsu;
    assign bus.ifu_resp_valid = ifu_resp_q;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.lsu_resp_valid = lsu_resp_q;
    assign bus.lsu_rdata      = lsu_rdata_q;
    assign bus.mem_req_valid  = (state_q == REQ);
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wen        = wen_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wmask      = wmask_q;
    assign busy               = (state_q != IDLE);
    assign owner              = owner_q;
endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: reset, single read, delayed store,
// round-robin ties with back-to-back grants, and reset during an outstanding request.
module tb_ysyx_23060332_mem_arbiter;
    logic clk;
    logic rst_n;
    logic busy;
    logic owner;
    int   total_cnt;
    int   bad_cnt;

    ysyx_23060332_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ysyx_23060332_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge so registered outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.ifu_req_valid  = 1'b0;
        bus.ifu_addr       = '0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_addr       = '0;
        bus.lsu_wen        = 1'b0;
        bus.lsu_wdata      = '0;
        bus.lsu_wmask      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
    endtask

    initial begin
        logic exp_lsu;
        logic prev_lsu;
        total_cnt = 0;
        bad_cnt   = 0;

        // Reset held with every input active.
        rst_n              = 1'b0;
        bus.ifu_req_valid  = 1'b1;
        bus.ifu_addr       = 32'hFFFF_FFFF;
        bus.lsu_req_valid  = 1'b1;
        bus.lsu_addr       = 32'hFFFF_FFFF;
        bus.lsu_wen        = 1'b1;
        bus.lsu_wdata      = 32'hFFFF_FFFF;
        bus.lsu_wmask      = 4'hF;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ifu_ready", bus.ifu_req_ready, 0);
        checkOutput("rst_lsu_ready", bus.lsu_req_ready, 0);
        checkOutput("rst_ifu_resp", bus.ifu_resp_valid, 0);
        checkOutput("rst_lsu_resp", bus.lsu_resp_valid, 0);
        checkOutput("rst_mem_valid", bus.mem_req_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_owner", owner, 0);
        checkOutput("rst_mem_fields", {bus.mem_addr, bus.mem_wen, bus.mem_wmask}, 0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
        checkOutput("rst_ifu_rdata", bus.ifu_rdata, 0);
        checkOutput("rst_lsu_rdata", bus.lsu_rdata, 0);
        clearInputs();
        rst_n = 1'b1;
        tick();

        // Single IFU read, memory ready immediately, response two cycles after accept.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0000;
        #1;
        checkOutput("rd_ifu_ready", bus.ifu_req_ready, 1);
        checkOutput("rd_lsu_ready", bus.lsu_req_ready, 0);
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        #1;
        checkOutput("rd_mem_valid", bus.mem_req_valid, 1);
        checkOutput("rd_mem_addr", bus.mem_addr, 64'h8000_0000);
        checkOutput("rd_mem_wen", bus.mem_wen, 0);
        checkOutput("rd_busy", busy, 1);
        checkOutput("rd_owner", owner, 0);
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_0413;
        #1;
        checkOutput("rd_wait_mem_valid", bus.mem_req_valid, 0);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        #1;
        checkOutput("rd_ifu_resp", bus.ifu_resp_valid, 1);
        checkOutput("rd_ifu_rdata", bus.ifu_rdata, 64'h413);
        checkOutput("rd_lsu_resp", bus.lsu_resp_valid, 0);
        checkOutput("rd_idle_busy", busy, 0);
        tick();
        checkOutput("rd_ifu_resp_pulse", bus.ifu_resp_valid, 0);
        checkOutput("rd_ifu_rdata_hold", bus.ifu_rdata, 64'h413);

        // LSU store, memory ready delayed three cycles; fields must stay registered.
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_1000;
        bus.lsu_wen       = 1'b1;
        bus.lsu_wdata     = 32'hDEAD_BEEF;
        bus.lsu_wmask     = 4'hF;
        #1;
        checkOutput("st_lsu_ready", bus.lsu_req_ready, 1);
        tick();
        bus.lsu_req_valid = 1'b0;
        bus.lsu_addr      = 32'h1111_1111;
        bus.lsu_wen       = 1'b0;
        bus.lsu_wdata     = 32'h2222_2222;
        bus.lsu_wmask     = 4'h3;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("st_hold_valid%0d", i), bus.mem_req_valid, 1);
            checkOutput($sformatf("st_hold_addr%0d", i), {bus.mem_wen, bus.mem_wmask, bus.mem_addr},
                        {27'd0, 1'b1, 4'hF, 32'h8000_1000});
            checkOutput($sformatf("st_hold_wdata%0d", i), bus.mem_wdata, 64'hDEAD_BEEF);
            checkOutput($sformatf("st_hold_ready%0d", i), bus.lsu_req_ready, 0);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        #1;
        checkOutput("st_owner", owner, 1);
        tick();
        bus.mem_req_ready = 1'b0;
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1234_5678;
        #1;
        checkOutput("st_wait_no_resp", bus.lsu_resp_valid, 0);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        checkOutput("st_lsu_resp", bus.lsu_resp_valid, 1);
        checkOutput("st_ifu_resp", bus.ifu_resp_valid, 0);
        checkOutput("st_lsu_rdata", bus.lsu_rdata, 64'h1234_5678);
        checkOutput("st_ifu_rdata_hold", bus.ifu_rdata, 64'h413);
        tick();

        // Fresh reset, then both requesters valid continuously: LSU, IFU, LSU, IFU.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        checkOutput("tie_owner_rst", owner, 0);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0004;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_2000;
        bus.lsu_wen       = 1'b0;
        bus.lsu_wdata     = '0;
        bus.lsu_wmask     = '0;
        prev_lsu = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_lsu = (i % 2 == 0);
            #1;
            checkOutput($sformatf("tie_lsu_ready%0d", i), bus.lsu_req_ready, exp_lsu);
            checkOutput($sformatf("tie_ifu_ready%0d", i), bus.ifu_req_ready, !exp_lsu);
            if (i > 0) begin
                checkOutput($sformatf("b2b_lsu_resp%0d", i), bus.lsu_resp_valid, prev_lsu);
                checkOutput($sformatf("b2b_ifu_resp%0d", i), bus.ifu_resp_valid, !prev_lsu);
            end
            tick();
            bus.mem_req_ready = 1'b1;
            #1;
            checkOutput($sformatf("tie_owner%0d", i), owner, exp_lsu);
            checkOutput($sformatf("tie_addr%0d", i), bus.mem_addr,
                        exp_lsu ? 64'h8000_2000 : 64'h8000_0004);
            tick();
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = 32'hA0 + i;
            tick();
            bus.mem_resp_valid = 1'b0;
            prev_lsu = exp_lsu;
        end
        #1;
        checkOutput("tie_last_ifu_resp", bus.ifu_resp_valid, 1);
        checkOutput("tie_last_ifu_rdata", bus.ifu_rdata, 64'hA3);
        checkOutput("tie_last_lsu_rdata", bus.lsu_rdata, 64'hA2);
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        tick();

        // Reset while waiting for a response; the late response must be dropped.
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_3000;
        tick();
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        #1;
        checkOutput("abort_busy_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy_rst", busy, 0);
        checkOutput("abort_mem_valid", bus.mem_req_valid, 0);
        tick();
        rst_n = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h5555_AAAA;
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        checkOutput("abort_lsu_resp", bus.lsu_resp_valid, 0);
        checkOutput("abort_ifu_resp", bus.ifu_resp_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_lsu_rdata", bus.lsu_rdata, 0);
        tick();
        checkOutput("abort_lsu_resp2", bus.lsu_resp_valid, 0);
        checkOutput("abort_busy2", busy, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
